// File: rtl/ring_overlay_gen.sv
// Alarm "ring" icon overlay: draws font glyphs at a fixed screen box and runs
// the alarm ringing FSM (arm, blink, acknowledge, timeout, cooldown).
module ring_overlay_gen #(
  parameter int          X0             = 576,
  parameter int          Y0             = 320,
  parameter int          GLYPHS         = 2,
  parameter int          SCALE_LOG2     = 2,
  parameter int          BASE_CHAR      = 6,
  parameter logic [11:0] FG             = 12'hF00,
  parameter logic [11:0] BG             = 12'h214,
  parameter logic [11:0] ARMED          = 12'h888,
  parameter int          BLINK_FRAMES   = 30,
  parameter int          TIMEOUT_FRAMES = 1800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        frame_tick,
  input  logic        alarm_en,
  input  logic        alarm_match,
  input  logic        ack,
  output logic [3:0]  rom_char,
  output logic [3:0]  rom_row,
  input  logic [7:0]  rom_data,
  output logic [11:0] rgb_out,
  output logic        ringing
);

  localparam int W  = (GLYPHS * 8) << SCALE_LOG2;
  localparam int H  = 16 << SCALE_LOG2;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int TW = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, RING_ON, RING_OFF, COOLDOWN} state_t;

  state_t        state;
  logic [BW-1:0] blink_cnt;
  logic [TW-1:0] timeout_cnt;

  logic [9:0] dx, dy;
  logic       in_box_c;
  logic [3:0] char_c, row_c;
  logic [2:0] col_c;

  logic [2:0] col1, col2;
  logic       in_box1, in_box2;
  logic       von1, von2;
  logic       pix_bit;

  always_comb begin
    dx       = pix_x - 10'(X0);
    dy       = pix_y - 10'(Y0);
    in_box_c = (int'(pix_x) >= X0) && (int'(pix_x) < X0 + W) &&
               (int'(pix_y) >= Y0) && (int'(pix_y) < Y0 + H);
    char_c   = 4'(BASE_CHAR) + 4'(dx >> (3 + SCALE_LOG2));
    col_c    = 3'(dx >> SCALE_LOG2);
    row_c    = 4'(dy >> SCALE_LOG2);
    pix_bit  = rom_data[3'd7 - col2];
  end

  // Stage 1 addresses the ROM; stage 2 waits out the ROM read; rgb_out at edge k+2.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_char <= '0;
      rom_row  <= '0;
      col1     <= '0;
      col2     <= '0;
      in_box1  <= 1'b0;
      in_box2  <= 1'b0;
      von1     <= 1'b0;
      von2     <= 1'b0;
      rgb_out  <= '0;
    end else begin
      rom_char <= char_c;
      rom_row  <= row_c;
      col1     <= col_c;
      in_box1  <= in_box_c;
      von1     <= video_on;
      col2     <= col1;
      in_box2  <= in_box1;
      von2     <= von1;
      if (!von2)
        rgb_out <= '0;
      else if (!in_box2)
        rgb_out <= BG;
      else begin
        unique case (state)
          RING_ON: rgb_out <= pix_bit ? FG : BG;
          IDLE:    rgb_out <= (alarm_en && pix_bit) ? ARMED : BG;
          default: rgb_out <= BG;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      blink_cnt   <= '0;
      timeout_cnt <= '0;
      ringing     <= 1'b0;
    end else if (!alarm_en) begin
      state   <= IDLE;
      ringing <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (alarm_match) begin
            state       <= RING_ON;
            blink_cnt   <= '0;
            timeout_cnt <= '0;
            ringing     <= 1'b1;
          end
        end
        RING_ON, RING_OFF: begin
          if (ack || (frame_tick && timeout_cnt == TLAST)) begin
            state   <= COOLDOWN;
            ringing <= 1'b0;
          end else if (frame_tick) begin
            timeout_cnt <= (timeout_cnt < TLAST) ? timeout_cnt + 1'b1 : timeout_cnt;
            if (blink_cnt == BLAST) begin
              blink_cnt <= '0;
              state     <= (state == RING_ON) ? RING_OFF : RING_ON;
            end else begin
              blink_cnt <= blink_cnt + 1'b1;
            end
          end
        end
        COOLDOWN: begin
          if (!alarm_match)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
